id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 138 +++++++++++++
 tb/tb_id_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: register file, per-register pending scoreboard, hazard stall and a one-entry output slot.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data to source reads.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_op,
  output logic            out_reg_write
);
  localparam int IW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend_reg;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_rs1_reg;
  logic [XLEN-1:0] out_rs2_reg;
  logic [4:0]      out_rd_reg;
  logic [6:0]      out_op_reg;
  logic            out_rw_reg;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       reg_write;
  logic       rs1_ok, rs2_ok, rd_ok, wb_ok;
  logic       byp_rs1, byp_rs2;
  logic       hazard;
  logic       accept;
  logic [XLEN-1:0] rdata1, rdata2;

  // Index 0 and indexes beyond the implemented file are never stored nor tracked.
  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign reg_write = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
                     (opcode == 7'b0000011) || (opcode == 7'b1101111) ||
                     (opcode == 7'b0110111);

  assign rs1_ok = idx_ok(rs1);
  assign rs2_ok = idx_ok(rs2);
  assign rd_ok  = idx_ok(rd);
  assign wb_ok  = wb_en && idx_ok(wb_rd);

`ifdef ID_WB_BYPASS_EN
  assign byp_rs1 = wb_ok && (wb_rd == rs1);
  assign byp_rs2 = wb_ok && (wb_rd == rs2);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (byp_rs1)     rdata1 = wb_data;
    else if (rs1_ok) rdata1 = regs[rs1[IW-1:0]];
    if (byp_rs2)     rdata2 = wb_data;
    else if (rs2_ok) rdata2 = regs[rs2[IW-1:0]];
  end

  // A source being written back this cycle is not a hazard when bypass is built in.
  assign hazard = in_valid &&
                  ((rs1_ok && pend_reg[rs1[IW-1:0]] && !byp_rs1) ||
                   (rs2_ok && pend_reg[rs2[IW-1:0]] && !byp_rs2) ||
                   (reg_write && rd_ok && pend_reg[rd[IW-1:0]]));

  assign in_ready = (!out_valid_reg || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    assign set_vec[gi] = accept && reg_write && rd_ok && (rd == 5'(gi));
    assign clr_vec[gi] = wb_ok && (wb_rd == 5'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[wb_rd[IW-1:0]] <= wb_data;
    end
  end

  // Set after clear so a same-cycle issue to the write-back index stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_reg <= '0;
    else        pend_reg <= (pend_reg & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_rs1_reg   <= '0;
      out_rs2_reg   <= '0;
      out_rd_reg    <= '0;
      out_op_reg    <= '0;
      out_rw_reg    <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_rs1_reg   <= rdata1;
      out_rs2_reg   <= rdata2;
      out_rd_reg    <= rd;
      out_op_reg    <= opcode;
      out_rw_reg    <= reg_write;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_rs1_data  = out_rs1_reg;
  assign out_rs2_data  = out_rs2_reg;
  assign out_rd        = out_rd_reg;
  assign out_op        = out_op_reg;
  assign out_reg_write = out_rw_reg;
endmodule

// File: tb/tb_id_stage.sv
// Randomized and directed bench for id_stage against a transaction-level register/scoreboard model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_reg_write;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic [6:0]  out_op;

  logic        s_in_ready, s_out_valid, s_out_reg_write;
  logic [31:0] s_out_rs1_data, s_out_rs2_data;
  logic [4:0]  s_out_rd;
  logic [6:0]  s_out_op;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_op(out_op),
    .out_reg_write(out_reg_write)
  );

  id_stage #(.XLEN(32), .NREGS(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_rs1_data(s_out_rs1_data), .out_rs2_data(s_out_rs2_data), .out_rd(s_out_rd), .out_op(s_out_op),
    .out_reg_write(s_out_reg_write)
  );

`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, outstanding-write set, and the single output slot.
  logic [31:0] m_reg [32];
  bit          m_pend [32];
  bit          m_ov;
  logic [31:0] m_rs1, m_rs2;
  logic [4:0]  m_rd;
  logic [6:0]  m_op;
  bit          m_rw;
  bit          last_rdy;
  int          n_acc = 0;

  function automatic bit is_rw(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b1101111 || op == 7'b0110111;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (BYP && wb_en && wb_rd == idx) return wb_data;
    return m_reg[idx];
  endfunction

  function automatic bit m_busy(input logic [4:0] idx);
    return idx != 0 && m_pend[idx] && !(BYP && wb_en && wb_rd == idx);
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_ov = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_op = '0; m_rw = 0;
  endtask

  // One clock cycle: drive at negedge, check in_ready before the edge, check outputs at next negedge.
  task automatic step(input bit v, input logic [31:0] ins, input bit we, input logic [4:0] wr,
                      input logic [31:0] wd, input bit ordy);
    logic [4:0] r1, r2, rd;
    logic [6:0] op;
    bit haz, exp_rdy, acc;
    logic [31:0] n1, n2;
    in_valid = v; instr = ins; wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
    #1;
    r1 = ins[19:15]; r2 = ins[24:20]; rd = ins[11:7]; op = ins[6:0];
    haz = v && (m_busy(r1) || m_busy(r2) || (is_rw(op) && rd != 0 && m_pend[rd]));
    exp_rdy = (!m_ov || ordy) && !haz;
    last_rdy = in_ready;
    check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    n1 = m_read(r1);
    n2 = m_read(r2);
    @(posedge clk);
    if (we && wr != 0) m_reg[wr] = wd;
    if (we) m_pend[wr] = 1'b0;
    if (acc && is_rw(op) && rd != 0) m_pend[rd] = 1'b1;
    if (acc) begin
      m_ov = 1; m_rs1 = n1; m_rs2 = n2; m_rd = rd; m_op = op; m_rw = is_rw(op);
      n_acc++;
    end else if (ordy) begin
      m_ov = 0;
    end
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b0;
    check("out_valid", out_valid, m_ov);
    check("out_rs1_data", out_rs1_data, m_rs1);
    check("out_rs2_data", out_rs2_data, m_rs2);
    check("out_rd", out_rd, m_rd);
    check("out_op", out_op, m_op);
    check("out_reg_write", out_reg_write, m_rw);
  endtask

  // Reset asserted mid-cycle with write-back requests that must be ignored.
  task automatic do_reset();
    rst_n = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rs1", out_rs1_data, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst16_out_valid", s_out_valid, 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    wb_en = 1'b0;
    rst_n = 1'b1;
  endtask

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic [6:0] ops [8];

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011; ops[3] = 7'b1101111;
    ops[4] = 7'b0110111; ops[5] = 7'b0100011; ops[6] = 7'b1100011; ops[7] = 7'b1110011;
    model_clear();
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_reg_write", out_reg_write, 0);
    rst_n = 1'b1;

    // Write x2, then read x4/x2 into an R-type writing x2.
    step(0, '0, 1, 5'd2, 32'hF0, 1);
    step(1, mk(OP_R, 5'd2, 5'd4, 5'd2), 0, '0, '0, 1);
    check("r026_valid", out_valid, 1);
    check("r026_rs1", out_rs1_data, 32'h0);
    check("r026_rs2", out_rs2_data, 32'hF0);
    check("r026_rw", out_reg_write, 1);

    // RAW stall on x5 until write-back.
    do_reset();
    step(1, mk(OP_R, 5'd5, 5'd0, 5'd0), 0, '0, '0, 1);
    step(1, mk(OP_R, 5'd6, 5'd5, 5'd0), 0, '0, '0, 1);
    check("r027_stall", last_rdy, 0);
    step(1, mk(OP_R, 5'd6, 5'd5, 5'd0), 1, 5'd5, 32'h1234, 1);
`ifndef ID_WB_BYPASS_EN
    check("r027_wb_cycle_stall", last_rdy, 0);
    step(1, mk(OP_R, 5'd6, 5'd5, 5'd0), 0, '0, '0, 1);
`endif
    check("r027_accept", last_rdy, 1);
    check("r027_rs1", out_rs1_data, 32'h1234);

    // Backpressure holds the slot; release accepts the waiting offer.
    do_reset();
    step(1, mk(OP_R, 5'd11, 5'd0, 5'd0), 0, '0, '0, 1);
    step(1, mk(OP_R, 5'd10, 5'd8, 5'd9), 0, '0, '0, 0);
    check("r028_blocked", last_rdy, 0);
    check("r028_hold_rd", out_rd, 5'd11);
    step(1, mk(OP_R, 5'd10, 5'd8, 5'd9), 0, '0, '0, 1);
    check("r028_accept", last_rdy, 1);
    check("r028_new_rd", out_rd, 5'd10);

    // x0 is hardwired; a store never marks its rd field pending.
    do_reset();
    step(0, '0, 1, 5'd0, 32'hFFFF_FFFF, 1);
    step(1, mk(OP_ST, 5'd3, 5'd0, 5'd0), 0, '0, '0, 1);
    check("r029_rs1", out_rs1_data, 0);
    check("r029_rw", out_reg_write, 0);
    step(1, mk(OP_R, 5'd4, 5'd3, 5'd3), 0, '0, '0, 1);
    check("r029_x3_free", last_rdy, 1);

    // Out-of-range index on a 16-entry file, then asynchronous reset with a held output.
    do_reset();
    step(0, '0, 1, 5'd20, 32'hAA, 1);
    step(1, mk(OP_R, 5'd12, 5'd20, 5'd0), 0, '0, '0, 0);
    check("r030_main_rs1", out_rs1_data, 32'hAA);
    check("r030_n16_valid", s_out_valid, 1);
    check("r030_n16_rs1", s_out_rs1_data, 0);
    do_reset();
    step(1, mk(OP_R, 5'd13, 5'd12, 5'd0), 0, '0, '0, 1);
    check("r021_pend_cleared", last_rdy, 1);

    // Same-cycle clear and set of x7 leaves it pending.
    do_reset();
    step(1, mk(OP_R, 5'd7, 5'd0, 5'd0), 1, 5'd7, 32'h77, 1);
    check("r031_issue", last_rdy, 1);
    step(1, mk(OP_R, 5'd8, 5'd7, 5'd0), 0, '0, '0, 1);
    check("r031_stall", last_rdy, 0);

    // Randomized traffic over a small register window to provoke hazards.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r1, r2, rd, wr;
      logic [6:0] op;
      bit v, we, ordy;
      bit wide;
      wide = ($urandom_range(0, 7) == 0);
      r1 = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rd = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wr = 5'($urandom_range(0, 7));
      op = ops[$urandom_range(0, 7)];
      v = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 4);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, mk(op, rd, r1, r2) | ({$urandom} & 32'hFE00_7000), we, wr, $urandom, ordy);
    end
    if (n_acc < 100) begin
      n_err++;
      $display("FAIL random_progress: got %0d acceptances expected at least 100", n_acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
